seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit 7-segment display.
- Shares one 4-to-16 digit-select decoder and one hex-to-segment path between NUM_DIGITS digit requesters.
- Rotates through the digits, driving the decoder index and enable and presenting the selected digit's nibble.
- Inserts a blanking interval at the start of each slot to suppress ghosting.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..16.
- DIV, 50000, clock cycles per digit slot; must be >= 2.
- BLANK, 16, cycles at the start of each slot with the decoder disabled; must satisfy 0 <= BLANK < DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  scan run request; synchronous, sampled on clk.
- digits_i  input  4*NUM_DIGITS  digit nibbles; digit k occupies bits [4k+3:4k], digit 0 is least significant.
- dp_i  input  NUM_DIGITS  decimal-point request per digit.
- dec_in  output  4  digit index to the 4-to-16 decoder.
- dec_enable  output  1  decoder enable; high only in the drive phase of a slot.
- nibble_o  output  4  nibble of the currently selected digit, to the segment decoder.
- dp_o  output  1  decimal point of the currently selected digit.
- frame_o  output  1  one-cycle pulse on the last cycle of the final slot of a frame.

Behaviour:
- Registers: state {IDLE, ACTIVE}, slot counter cnt (width clog2(DIV)), index idx (4 bits), shadow registers shd_dig (4*NUM_DIGITS) and shd_dp (NUM_DIGITS).
- All outputs are Moore decodes of these registers; no added output latency.
- Reset (rst_n low, asynchronous): state=IDLE, cnt=0, idx=0, shadows=0. Outputs dec_in=0, dec_enable=0, nibble_o=0, dp_o=0, frame_o=0.
- IDLE: all outputs 0.
  - On a clk edge with enable=1: go to ACTIVE, cnt=0, idx=0, load shadows from digits_i/dp_i.
- ACTIVE: cnt increments each cycle.
  - Blank phase: cnt < BLANK. dec_enable=0.
  - Drive phase: cnt >= BLANK. dec_enable=1.
  - dec_in=idx, nibble_o=shd_dig[idx], dp_o=shd_dp[idx] for the whole slot, including the blank phase.
- Slot end (cnt == DIV-1): next edge sets cnt=0 and idx=idx+1.
- Frame end (idx == NUM_DIGITS-1 and cnt == DIV-1):
  - frame_o=1 in that cycle.
  - Next edge wraps idx to 0 and reloads shadows.
  - Display updates only at frame boundaries, so no tearing.
- Timing: one slot is DIV cycles; one frame is NUM_DIGITS*DIV cycles.
- NUM_DIGITS=1: idx stays 0; frame_o pulses every DIV cycles.
- enable low while ACTIVE: next edge goes to IDLE with cnt=0 and idx=0; outputs 0 from that edge. The shadows hold their values, but restart reloads them.
- enable low in the same cycle as frame end: IDLE wins; frame_o still pulses in that cycle.
- digits_i/dp_i changes mid-frame have no effect until the next reload.
- rst_n asserted mid-slot: immediate return to reset values, independent of clk.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - At each shadow load, compute a NUM_DIGITS-bit suppress mask.
  - Digit k is suppressed if k > 0 and every shd_dig nibble from k up to NUM_DIGITS-1 is zero.
  - In a suppressed slot, dec_enable stays 0 for the whole slot.
  - Slot timing, idx and frame_o are unchanged.
  - Digit 0 is never suppressed.
- Not defined: no mask logic; every slot drives normally.

Test Plan (NUM_DIGITS=4, DIV=8, BLANK=2 unless stated):
- Reset: assert rst_n=0 mid drive phase with no clk edge -> dec_enable, dec_in, nibble_o, dp_o, frame_o all 0 immediately.
- Scan order: digits_i=16'h4321, dp_i=4'b0100, enable=1 ->
  - nibble_o sequence 1,2,3,4 with dec_in 0,1,2,3.
  - Per slot, dec_enable is 0 for 2 cycles then 1 for 6 cycles.
  - dp_o=1 only in slot 2.
  - frame_o pulses once every 32 cycles, on the last cycle of slot 3.
- Tear-free update: change digits_i to 16'h8765 during slot 1 -> slots 2,3 show 3,4; next frame shows 5,6,7,8.
- Enable drop: enable=0 during slot 2 -> next edge dec_enable=0 and dec_in=0. Re-enable -> restart at idx 0 with a fresh snapshot, first drive phase after 2 blank cycles.
- NUM_DIGITS=3, DIV=4, BLANK=0 -> idx sequence 0,1,2,0; dec_enable constantly 1; frame_o every 12 cycles.
- LEADING_ZERO_BLANK_EN with digits_i=16'h0050:
  - Defined: slots 3 and 2 have dec_enable=0 throughout; slot 1 drives 5; slot 0 drives 0.
  - Not defined: all four slots drive 0,5,0,0 for idx 0..3.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Requester/display bus for seg_scan_ctrl.
// master: digit requester side (drives enable, nibbles, decimal points).
// slave : scan controller side (drives decoder index/enable and segment data).
interface seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    enable;
   logic [4*NUM_DIGITS-1:0] digits_i;
   logic [NUM_DIGITS-1:0]   dp_i;
   logic [3:0]              dec_in;
   logic                    dec_enable;
   logic [3:0]              nibble_o;
   logic                    dp_o;
   logic                    frame_o;

   modport master (
      output enable, digits_i, dp_i,
      input  dec_in, dec_enable, nibble_o, dp_o, frame_o
   );

   modport slave (
      input  enable, digits_i, dp_i,
      output dec_in, dec_enable, nibble_o, dp_o, frame_o
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller.
// Rotates through NUM_DIGITS slots of DIV cycles each; the first BLANK cycles
// of every slot keep the decoder disabled to suppress ghosting. Digit data is
// snapshotted at frame boundaries so a frame never shows a mix of old and new.
// Optional macro LEADING_ZERO_BLANK_EN: keeps the decoder disabled in slots
// holding leading zeros (digit 0 is always shown).
module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int DIV        = 50000,
   parameter int BLANK      = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   seg_scan_ctrl_if.slave bus
);
   localparam int CW = $clog2(DIV);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                  state_q;
   logic [CW-1:0]           cnt_q;
   logic [3:0]              idx_q;
   logic [4*NUM_DIGITS-1:0] shd_dig_q;
   logic [NUM_DIGITS-1:0]   shd_dp_q;

   logic        active, slot_end, last_idx, frame_end, drive_ph;
   logic [15:0][3:0] dig16;
   logic [15:0] dp16, supp16;

   assign active    = (state_q == ACTIVE);
   assign slot_end  = (cnt_q == CW'(DIV-1));
   assign last_idx  = (idx_q == 4'(NUM_DIGITS-1));
   assign frame_end = active && slot_end && last_idx;

   // Drive phase covers the slot after the blanking interval.
   generate
      if (BLANK == 0) begin : g_noblank
         assign drive_ph = 1'b1;
      end else begin : g_blank
         assign drive_ph = (cnt_q >= CW'(BLANK));
      end
   endgenerate

`ifdef LEADING_ZERO_BLANK_EN
   logic                  load;
   logic                  zrun;
   logic [NUM_DIGITS-1:0] supp_d, supp_q;

   assign load = bus.enable && (!active || frame_end);

   // Suppress digit k (k>0) when it and every more-significant digit is zero.
   always_comb begin
      zrun   = 1'b1;
      supp_d = '0;
      for (int k = NUM_DIGITS-1; k >= 0; k--) begin
         zrun      = zrun & (bus.digits_i[4*k +: 4] == 4'd0);
         supp_d[k] = zrun & (k != 0);
      end
   end

   // Mask is captured together with the shadow snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    supp_q <= '0;
      else if (load) supp_q <= supp_d;
   end
`endif

   // Zero-padded 16-entry views so the 4-bit index can select directly.
   always_comb begin
      dig16  = '0;
      dp16   = '0;
      supp16 = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         dig16[k] = shd_dig_q[4*k +: 4];
         dp16[k]  = shd_dp_q[k];
`ifdef LEADING_ZERO_BLANK_EN
         supp16[k] = supp_q[k];
`endif
      end
   end

   // Scan FSM: slot counter, digit index and frame-boundary snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shd_dig_q <= '0;
         shd_dp_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.enable) begin
                  state_q   <= ACTIVE;
                  cnt_q     <= '0;
                  idx_q     <= '0;
                  shd_dig_q <= bus.digits_i;
                  shd_dp_q  <= bus.dp_i;
               end
            end
            ACTIVE: begin
               if (!bus.enable) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  idx_q   <= '0;
               end else if (slot_end) begin
                  cnt_q <= '0;
                  if (last_idx) begin
                     idx_q     <= '0;
                     shd_dig_q <= bus.digits_i;
                     shd_dp_q  <= bus.dp_i;
                  end else begin
                     idx_q <= idx_q + 4'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Moore output decode; everything is quiet while idle.
   assign bus.dec_in     = active ? idx_q : 4'd0;
   assign bus.dec_enable = active && drive_ph && !supp16[idx_q];
   assign bus.nibble_o   = active ? dig16[idx_q] : 4'd0;
   assign bus.dp_o       = active && dp16[idx_q];
   assign bus.frame_o    = frame_end;
endmodule
